bram_burst_wrapper: RTL and testbench

BRAM_BURST_WRAPPER -- requirements
Module: bram_burst_wrapper

---
 rtl/bram_burst_wrapper.sv | 171 +++++++++++++++++
 tb/tb_bram_burst_wrapper.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_burst_wrapper.sv
// bram_burst_wrapper: burst front-end over a behavioural single-port BRAM
// with a programmable access delay and FIXED/INCR/WRAP beat addressing.
module bram_burst_wrapper #(
  parameter bit SIMULATION = 1'b0,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_BITS  = 18,
  parameter int DELAY_SIM  = 2,
  parameter int DELAY_SYN  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid,
  input  logic [63:0]             addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic [DATA_WIDTH/8-1:0] wstrobe,
  input  logic [1:0]              burst,
  input  logic [7:0]              len,
  output logic                    ready,
  output logic                    last
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(NB);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int SW    = ADDR_BITS + 8;
  localparam int unsigned DELAY =
    SIMULATION ? DELAY_SIM : DELAY_SYN;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    XFER,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_BITS-1:0]  base;
  logic [1:0]            burst_q;
  logic [7:0]            len_q;
  logic                  wr_q;
  logic [31:0]           dcnt;
  logic [7:0]            beat;
  logic                  rd_vld;
  logic                  rd_last;
  logic                  latch;
  logic                  we;
  logic                  re;
  logic                  beat_end;
  logic [ADDR_BITS-1:0]  baddr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [SW-1:0] base_x;
  logic [SW-1:0] sum_x;
  logic [SW-1:0] mask_x;
  logic [SW-1:0] wrap_x;
  logic          wrap_ok;
  logic          is_wrap;
  logic          is_incr;
  logic          unused;

  assign unused = ^{addr[63:ADDR_BITS+OFF],
                    addr[OFF-1:0],
                    sum_x[SW-1:ADDR_BITS],
                    wrap_x[SW-1:ADDR_BITS]};

  assign beat_end = (beat == len_q);

  // Beat address; WRAP only for power-of-two beat counts 2..16
  assign base_x  = {8'd0, base};
  assign sum_x   = base_x + {{ADDR_BITS{1'b0}}, beat};
  assign mask_x  = {{ADDR_BITS{1'b0}}, len_q};
  assign wrap_x  = (base_x & ~mask_x) | (sum_x & mask_x);
  assign wrap_ok = (len_q == 8'd1) || (len_q == 8'd3) ||
                   (len_q == 8'd7) || (len_q == 8'd15);
  assign is_wrap = (burst_q == 2'd2) && wrap_ok;
  assign is_incr = (burst_q == 2'd1) ||
                   ((burst_q == 2'd2) && !wrap_ok);

  always_comb begin
    baddr = base;
    unique case (1'b1)
      is_wrap: baddr = wrap_x[ADDR_BITS-1:0];
      is_incr: baddr = sum_x[ADDR_BITS-1:0];
      default: baddr = base;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (valid) state_nx = WAIT;
      end
      WAIT: begin
        if (!valid)             state_nx = IDLE;
        else if (dcnt == DELAY) state_nx = XFER;
      end
      XFER: begin
        if (!valid)        state_nx = IDLE;
        else if (beat_end) state_nx = wr_q ? DONE : DRAIN;
      end
      DRAIN:   state_nx = valid ? DONE : IDLE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    latch = 1'b0;
    we    = 1'b0;
    re    = 1'b0;
    unique case (state)
      IDLE: latch = valid;
      XFER: begin
        we = valid & wr_q;
        re = valid & ~wr_q;
      end
      default: ;
    endcase
  end

  // A registered read beat is dropped if valid falls while it is shown
  assign ready = we | (rd_vld & valid);
  assign last  = (we & beat_end) | (rd_vld & rd_last & valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base    <= '0;
      burst_q <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      dcnt    <= '0;
      beat    <= '0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      rdata   <= '0;
    end else begin
      rd_vld  <= re;
      rd_last <= re & beat_end;
      if (latch) begin
        base    <= addr[ADDR_BITS+OFF-1:OFF];
        burst_q <= burst;
        len_q   <= len;
        wr_q    <= |wstrobe;
        dcnt    <= '0;
        beat    <= '0;
      end
      if (state == WAIT) dcnt <= dcnt + 32'd1;
      if (we | re)       beat <= beat + 8'd1;
      if (re)            rdata <= mem[baddr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrobe[i]) mem[baddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bram_burst_wrapper.sv
// Scoreboard bench for bram_burst_wrapper: random and directed bursts
// checked against an array model with spec-level beat timing.
module tb_bram_burst_wrapper;

  localparam int DW    = 64;
  localparam int AB    = 10;
  localparam int DEPTH = 1 << AB;
  localparam int D     = 2;
  localparam int OFF   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          valid = 1'b0;
  logic [63:0]   addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic [7:0]    wstrobe = '0;
  logic [1:0]    burst = '0;
  logic [7:0]    len = '0;
  logic          ready;
  logic          last;

  bram_burst_wrapper #(
    .SIMULATION(1'b1),
    .DATA_WIDTH(DW),
    .ADDR_BITS(AB),
    .DELAY_SIM(D),
    .DELAY_SYN(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .valid(valid),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .wstrobe(wstrobe),
    .burst(burst),
    .len(len),
    .ready(ready),
    .last(last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [63:0] data;
    bit          lst;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mref [DEPTH];
  int          checks = 0;
  int          errors = 0;

  function automatic int word_of(int base, int bt, int ln, int b);
    int n;
    n = ln + 1;
    if (bt == 1 || (bt == 2 && !(n == 2 || n == 4 || n == 8 || n == 16)))
      return (base + b) % DEPTH;
    if (bt == 2)
      return base - (base % n) + ((base + b) % n);
    return base;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act %h req %h", nm, act, req);
    end
  endtask

  // Drives one burst from an IDLE cycle; abort_k >= 1 drops valid at that write beat
  task automatic run_txn(input logic [63:0] a, input int bt, input int ln,
                         input bit wr, input logic [7:0] strb,
                         input bit seqd, input int abort_k);
    int c0, base, total, b, w;
    logic [7:0]  s;
    logic [63:0] d;
    c0 = cyc;
    base = int'((a >> OFF) % DEPTH);
    valid = 1'b1;
    addr = a;
    burst = bt[1:0];
    len = ln[7:0];
    wstrobe = wr ? ((strb != 8'h00) ? strb : 8'hFF) : 8'h00;
    wdata = {$urandom, $urandom};
    total = wr ? D + 3 + ln : D + 4 + ln;
    for (int k = 0; k < total; k++) begin
      if (k > 0) begin
        addr = {$urandom, $urandom};
        burst = 2'($urandom);
        len = 8'($urandom);
      end
      b = k - (D + 2);
      if (b >= 0 && b <= ln) begin
        w = word_of(base, bt, ln, b);
        if (wr) begin
          if (abort_k >= 0 && b == abort_k) begin
            valid = 1'b0;
            @(posedge clk);
            #1;
            return;
          end
          s = (strb != 8'h00) ? strb : 8'($urandom);
          d = seqd ? 64'(b) : {$urandom, $urandom};
          wstrobe = s;
          wdata = d;
          for (int i = 0; i < 8; i++)
            if (s[i]) mref[w][i*8 +: 8] = d[i*8 +: 8];
          q.push_back('{c0 + k, 1'b0, 64'd0, (b == ln)});
        end else begin
          q.push_back('{c0 + k + 1, 1'b1, mref[w], (b == ln)});
        end
      end
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_beat act none req cyc %0d", e.cyc);
    end
    if (ready) begin
      checks++;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        errors++;
        $display("FAIL spurious_ready cyc %0d act 1 req 0", cyc);
      end else begin
        e = q.pop_front();
        checks++;
        if (last !== e.lst) begin
          errors++;
          $display("FAIL beat_last cyc %0d act %b req %b", cyc, last, e.lst);
        end
        if (e.rd) begin
          checks++;
          if (rdata !== e.data) begin
            errors++;
            $display("FAIL beat_rdata cyc %0d act %h req %h",
                     cyc, rdata, e.data);
          end
        end
      end
    end else if (last) begin
      checks++;
      errors++;
      $display("FAIL last_without_ready cyc %0d act 1 req 0", cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog act timeout req finish");
    $fatal(1);
  end

  initial begin
    int bt, ln, ab;
    bit wr;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_last", 64'(last), 64'd0);
    chk("reset_rdata", rdata, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int p = 0; p < DEPTH / 256; p++)
      run_txn(64'(p * 256 * 8), 1, 255, 1'b1, 8'hFF, 1'b0, -1);

    run_txn(64'h40, 1, 3, 1'b1, 8'hFF, 1'b1, -1);
    run_txn(64'h40, 1, 3, 1'b0, 8'h00, 1'b0, -1);
    chk("incr_model_w11", mref[11], 64'd3);
    run_txn(64'h70, 2, 3, 1'b0, 8'h00, 1'b0, -1);
    run_txn(64'h8, 0, 2, 1'b1, 8'h0F, 1'b0, -1);
    run_txn(64'h8, 0, 0, 1'b0, 8'h00, 1'b0, -1);
    run_txn(64'h200, 1, 7, 1'b1, 8'hFF, 1'b0, 2);
    run_txn(64'h200, 1, 7, 1'b0, 8'h00, 1'b0, -1);
    run_txn(64'h100, 3, 3, 1'b0, 8'h00, 1'b0, -1);
    run_txn(64'h128, 2, 2, 1'b0, 8'h00, 1'b0, -1);

    valid = 1'b1;
    addr = 64'h48;
    burst = 2'd1;
    len = 8'd0;
    wstrobe = 8'h00;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_ready", 64'(ready), 64'd0);
    chk("async_rst_last", 64'(last), 64'd0);
    chk("async_rst_rdata", rdata, 64'd0);
    valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_txn(64'h48, 1, 0, 1'b0, 8'h00, 1'b0, -1);

    run_txn(64'((DEPTH - 1) * 8), 1, 1, 1'b0, 8'h00, 1'b0, -1);
    run_txn(64'h10, 1, 0, 1'b1, 8'h00, 1'b0, -1);

    for (int t = 0; t < 40; t++) begin
      bt = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) ln = $urandom_range(0, 40);
      else ln = $urandom_range(0, 15);
      wr = 1'($urandom_range(0, 1));
      ab = -1;
      if (wr && ln > 0 && $urandom_range(0, 4) == 0)
        ab = $urandom_range(1, ln);
      run_txn({$urandom, $urandom}, bt, ln, wr, 8'h00, 1'b0, ab);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
